// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit with HI/LO accumulator for the execute stage.
// Shift-add multiply and restoring divide, one bit per cycle, start/busy/done handshake.
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             flush,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    // op[2:1]: 00 multiply, 01 divide, 10 multiply-add, 11 multiply-subtract
    typedef enum logic [1:0] {K_MUL = 2'b00, K_DIV = 2'b01, K_MADD = 2'b10, K_MSUB = 2'b11} kind_t;

    state_t state, state_next;
    kind_t  kind;

    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] prod, mcand;
    logic [WIDTH-1:0]   mplier, rem, quo;

    logic               accept;
    logic               a_neg_in, b_neg_in;
    logic [WIDTH-1:0]   a_mag_in, b_mag_in;
    logic [WIDTH:0]     rem_shift, rem_trial;
    logic [2*WIDTH-1:0] prod_s, fin_hilo;
    logic [WIDTH-1:0]   quo_s, rem_s, a_raw;

    assign accept = start && !busy && !flush;

    // Unsigned variants (op[0]=1) use the raw operands as magnitudes.
    assign a_neg_in = !op[0] && A[WIDTH-1];
    assign b_neg_in = !op[0] && B[WIDTH-1];
    assign a_mag_in = a_neg_in ? -A : A;
    assign b_mag_in = b_neg_in ? -B : B;

    // Restoring step: the borrow bit of the trial subtraction decides the quotient bit.
    assign rem_shift = {rem, quo[WIDTH-1]};
    assign rem_trial = rem_shift - {1'b0, b_mag};

    assign prod_s = (sign_a ^ sign_b) ? -prod : prod;
    assign quo_s  = (sign_a ^ sign_b) ? -quo : quo;
    assign rem_s  = sign_a ? -rem : rem;
    assign a_raw  = sign_a ? -a_mag : a_mag;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    always_comb begin
        fin_hilo = prod_s;
        case (kind)
            K_DIV:   fin_hilo = (b_mag == '0) ? {a_raw, {WIDTH{1'b1}}} : {rem_s, quo_s};
            K_MADD:  fin_hilo = {HI, LO} + prod_s;
            K_MSUB:  fin_hilo = {HI, LO} - prod_s;
            default: fin_hilo = prod_s;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FIN) && !flush;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind   <= K_MUL;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            a_mag  <= '0;
            b_mag  <= '0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            rem    <= '0;
            quo    <= '0;
        end else if (accept) begin
            kind   <= kind_t'(op[2:1]);
            sign_a <= a_neg_in;
            sign_b <= b_neg_in;
            a_mag  <= a_mag_in;
            b_mag  <= b_mag_in;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= {{WIDTH{1'b0}}, a_mag_in};
            mplier <= b_mag_in;
            rem    <= '0;
            quo    <= a_mag_in;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (kind == K_DIV) begin
                if (!rem_trial[WIDTH]) begin
                    rem <= rem_trial[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b1};
                end else begin
                    rem <= rem_shift[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (mplier[0]) prod <= prod + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    // Flush blocks both the FIN write and idle MTHI/MTLO writes; idle writes land before a same-edge start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            HI <= '0;
            LO <= '0;
        end else if (!flush) begin
            if (state == FIN) begin
                {HI, LO} <= fin_hilo;
            end else if (!busy) begin
                if (hi_we) HI <= wdata;
                if (lo_we) LO <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: scoreboard of HI/LO results from a reference model,
// plus handshake, flush, reset and WIDTH=8 checks.
module tb_mdu_iter;

    localparam logic [2:0] MULT = 3'b000, MULTU = 3'b001, DIV = 3'b010, DIVU = 3'b011;
    localparam logic [2:0] MADD = 3'b100, MADDU = 3'b101, MSUB = 3'b110, MSUBU = 3'b111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, flush = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0, b = '0, wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        start8 = 1'b0;
    logic [2:0]  op8 = 3'b000;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [7:0]  hi8, lo8;

    int          total = 0;
    int          bad = 0;
    logic [63:0] sb[$];
    logic [31:0] m_hi = '0, m_lo = '0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .A(a), .B(b),
        .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .HI(hi), .LO(lo)
    );

    mdu_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op8), .A(a8), .B(b8),
        .flush(1'b0), .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
        .busy(busy8), .done(done8), .HI(hi8), .LO(lo8)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] model_op(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
        logic signed [31:0] sx, sy;
        logic [63:0]        p;
        sx = x;
        sy = y;
        if (o[0]) p = {32'd0, x} * {32'd0, y};
        else      p = longint'(sx) * longint'(sy);
        case (o)
            DIV: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {sx % sy, sx / sy};
            end
            DIVU: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            MADD, MADDU: return acc + p;
            MSUB, MSUBU: return acc - p;
            default:     return p;
        endcase
    endfunction

    // Drives a start in the current cycle and pushes the model's result.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] r;
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        r = model_op(o, x, y, {m_hi, m_lo});
        {m_hi, m_lo} = r;
        sb.push_back(r);
    endtask

    // Runs to done; optionally pokes start+hi_we while busy in cycle `poke`.
    task automatic finish_op(input string tag, input int poke);
        int          n;
        bit          busy_ok;
        logic [63:0] e;
        busy_ok = 1'b1;
        tick();
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        n = 1;
        while (!done && n < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (n == poke) begin
                start = 1'b1;
                op = DIVU;
                a = 32'd1;
                b = 32'd1;
                hi_we = 1'b1;
                wdata = 32'hDEAD_BEEF;
            end
            tick();
            n++;
            if (n == poke + 1) begin
                start = 1'b0;
                hi_we = 1'b0;
            end
        end
        check({tag, " latency"}, n, 34);
        check({tag, " busy_window"}, busy_ok, 1);
        check({tag, " busy_in_done"}, busy, 0);
        e = (sb.size() > 0) ? sb.pop_front() : 64'd0;
        check({tag, " HI"}, hi, e[63:32]);
        check({tag, " LO"}, lo, e[31:0]);
    endtask

    initial begin
        int n;
        bit saw;

        #12;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset HI", hi, 0);
        check("reset LO", lo, 0);
        check("reset8 HI/LO", {hi8, lo8}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(MULT, 32'hFFFF_FFFD, 32'd7);          finish_op("mult_neg", 0);
        issue(DIVU, 32'd100, 32'd7);                finish_op("divu", 0);
        issue(DIV, 32'hFFFF_FFF9, 32'd2);           finish_op("div_neg", 0);
        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);   finish_op("div_ovf", 0);
        issue(DIVU, 32'd5, 32'd0);                  finish_op("div_zero", 0);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'd0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b0;
        check("mthi_mtlo HI", hi, m_hi);
        check("mthi_mtlo LO", lo, m_lo);

        issue(MSUB, 32'd1, 32'd1);                  finish_op("msub", 0);

        hi_we = 1'b1;
        wdata = 32'd0;
        m_hi = 32'd0;
        tick();
        hi_we = 1'b0;
        lo_we = 1'b1;
        wdata = 32'hFFFF_FFFF;
        m_lo = 32'hFFFF_FFFF;
        issue(MADDU, 32'd1, 32'd1);                 finish_op("maddu_wr", 0);

        for (int i = 0; i < 8; i++) begin
            issue(3'($urandom_range(0, 7)), $urandom, $urandom);
            finish_op("random", 0);
        end

        issue(MULTU, 32'h1234_5678, 32'h10);        finish_op("busy_ignore", 5);
        repeat (3) tick();
        check("no_queued_start", busy, 0);

        start = 1'b1;
        op = MULTU;
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        tick();
        start = 1'b0;
        n = 1;
        while (n < 10) begin
            tick();
            n++;
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush busy", busy, 0);
        check("flush HI", hi, m_hi);
        check("flush LO", lo, m_lo);
        saw = 1'b0;
        repeat (40) begin
            tick();
            if (done || busy) saw = 1'b1;
        end
        check("flush no_done", saw, 0);

        start = 1'b1;
        op = MULT;
        a = 32'd3;
        b = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("pre_reset busy", busy, 1);
        rst = 1'b1;
        #1;
        check("mid_reset busy", busy, 0);
        check("mid_reset done", done, 0);
        check("mid_reset HI", hi, 0);
        check("mid_reset LO", lo, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("post_reset idle", busy, 0);

        start8 = 1'b1;
        op8 = MULTU;
        a8 = 8'hFF;
        b8 = 8'hFF;
        tick();
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 50) begin
            tick();
            n++;
        end
        check("w8 mult latency", n, 10);
        check("w8 mult HI", hi8, 8'hFE);
        check("w8 mult LO", lo8, 8'h01);

        start8 = 1'b1;
        op8 = DIVU;
        a8 = 8'd200;
        b8 = 8'd7;
        tick();
        start8 = 1'b0;
        check("w8 b2b accept", busy8, 1);
        n = 1;
        while (!done8 && n < 50) begin
            tick();
            n++;
        end
        check("w8 div latency", n, 10);
        check("w8 div HI", hi8, 8'd4);
        check("w8 div LO", lo8, 8'd28);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
